csr_access_ctrl: RTL and testbench

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

---
 rtl/csr_access_ctrl_pkg.sv | 33 +++
 rtl/csr_access_ctrl_decode.sv | 58 +++++
 rtl/csr_access_ctrl.sv | 134 +++++++++++++
 tb/tb_csr_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_ctrl_pkg.sv
// Shared CSR definitions: op encodings, funct3 values, FSM states and the
// list of CSR addresses this core actually implements.
package csr_access_ctrl_pkg;

   // Operation handed to the CSR unit.
   typedef enum logic [1:0] {
      CSR_OP_RW = 2'b00,
      CSR_OP_RS = 2'b01,
      CSR_OP_RC = 2'b10
   } csr_op_e;

   // Access controller states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   // funct3 of the SYSTEM-opcode CSR instructions; 000 and 100 are not CSR ops.
   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   // Implemented CSRs: cycle, cycleh-style counter, mvendorid..mhartid, misa.
   localparam int NUM_IMPL_CSR = 7;
   localparam logic [NUM_IMPL_CSR-1:0][11:0] IMPL_CSR_ADDR = {
      12'h301, 12'hF14, 12'hF13, 12'hF12, 12'hF11, 12'hC80, 12'hC00
   };

endpackage

// File: rtl/csr_access_ctrl_decode.sv
// Combinational decode of a captured CSR instruction: operation, whether it
// writes the CSR at all, and whether it must be reported as illegal.
module csr_decode
   import csr_access_ctrl_pkg::*;
#(
   parameter bit CHECK_ADDR = 1'b1
) (
   input  logic [2:0]  funct3_i,
   input  logic [11:0] addr_i,
   input  logic [4:0]  rs1_idx_i,
   output logic [1:0]  op_o,
   output logic        wr_en_o,
   output logic        illegal_o
);

   logic [NUM_IMPL_CSR-1:0] addr_hit;
   logic                    f3_valid;
   logic                    addr_ok;
   logic                    ro_write;

   // One comparator per implemented address.
   generate
      for (genvar gi = 0; gi < NUM_IMPL_CSR; gi++) begin : g_addr_hit
         assign addr_hit[gi] = (addr_i == IMPL_CSR_ADDR[gi]);
      end
   endgenerate

   // funct3 -> op; set/clear with a zero source never writes the CSR.
   always_comb begin
      op_o     = CSR_OP_RW;
      wr_en_o  = 1'b0;
      f3_valid = 1'b0;
      case (funct3_i)
         F3_CSRRW, F3_CSRRWI: begin
            op_o     = CSR_OP_RW;
            wr_en_o  = 1'b1;
            f3_valid = 1'b1;
         end
         F3_CSRRS, F3_CSRRSI: begin
            op_o     = CSR_OP_RS;
            wr_en_o  = (rs1_idx_i != 5'd0);
            f3_valid = 1'b1;
         end
         F3_CSRRC, F3_CSRRCI: begin
            op_o     = CSR_OP_RC;
            wr_en_o  = (rs1_idx_i != 5'd0);
            f3_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Address space 11xx is read-only; writing it is illegal.
   assign ro_write  = (addr_i[11:10] == 2'b11) && wr_en_o;
   assign addr_ok   = !CHECK_ADDR || (|addr_hit);
   assign illegal_o = !f3_valid || ro_write || !addr_ok;

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: accepts one CSR instruction, issues a single-cycle
// access to the CSR unit, then returns the old CSR value as a response.
module csr_access_ctrl
   import csr_access_ctrl_pkg::*;
#(
   parameter bit CHECK_ADDR = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_funct3_i,
   input  logic [11:0] req_addr_i,
   input  logic [31:0] req_rs1_i,
   input  logic [4:0]  req_rs1_idx_i,
   input  logic [4:0]  req_rd_i,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_data_o,
   output logic [1:0]  csr_op_o,
   output logic        csr_we_o,
   input  logic [31:0] csr_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [4:0]  rsp_rd_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_we_o,
   output logic        rsp_illegal_o
);

   state_e      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [11:0] addr_q, addr_d;
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  rs1_idx_q, rs1_idx_d;
   logic [31:0] operand_q, operand_d;
   logic        rsp_illegal_q, rsp_illegal_d;
   logic        rsp_we_q, rsp_we_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   logic [1:0]  dec_op;
   logic        dec_wr_en;
   logic        dec_illegal;
   logic        req_fire;

   // Decode always looks at the captured request, so it is stable in ACCESS.
   csr_decode #(
      .CHECK_ADDR (CHECK_ADDR)
   ) u_decode (
      .funct3_i  (funct3_q),
      .addr_i    (addr_q),
      .rs1_idx_i (rs1_idx_q),
      .op_o      (dec_op),
      .wr_en_o   (dec_wr_en),
      .illegal_o (dec_illegal)
   );

   assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
   assign req_fire    = req_valid_i && req_ready_o;

   // Next-state logic: one access cycle, then hold the response until taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req_fire) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Datapath next values: capture on accept, build the response in ACCESS.
   always_comb begin
      funct3_d      = funct3_q;
      addr_d        = addr_q;
      rd_d          = rd_q;
      rs1_idx_d     = rs1_idx_q;
      operand_d     = operand_q;
      rsp_illegal_d = rsp_illegal_q;
      rsp_we_d      = rsp_we_q;
      rsp_data_d    = rsp_data_q;
      if (req_fire) begin
         funct3_d  = req_funct3_i;
         addr_d    = req_addr_i;
         rd_d      = req_rd_i;
         rs1_idx_d = req_rs1_idx_i;
         operand_d = req_funct3_i[2] ? {27'd0, req_rs1_idx_i} : req_rs1_i;
      end
      if (state_q == ST_ACCESS) begin
         rsp_illegal_d = dec_illegal;
         rsp_we_d      = (rd_q != 5'd0) && !dec_illegal;
         rsp_data_d    = dec_illegal ? 32'h0 : csr_data_i;
      end
   end

   // Datapath registers; reset discards any in-flight request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         funct3_q      <= 3'd0;
         addr_q        <= 12'd0;
         rd_q          <= 5'd0;
         rs1_idx_q     <= 5'd0;
         operand_q     <= 32'd0;
         rsp_illegal_q <= 1'b0;
         rsp_we_q      <= 1'b0;
         rsp_data_q    <= 32'd0;
      end else begin
         funct3_q      <= funct3_d;
         addr_q        <= addr_d;
         rd_q          <= rd_d;
         rs1_idx_q     <= rs1_idx_d;
         operand_q     <= operand_d;
         rsp_illegal_q <= rsp_illegal_d;
         rsp_we_q      <= rsp_we_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

   assign csr_addr_o    = addr_q;
   assign csr_op_o      = dec_op;
   assign csr_data_o    = operand_q;
   assign csr_we_o      = (state_q == ST_ACCESS) && dec_wr_en && !dec_illegal && !rst_i;
   assign rsp_valid_o   = (state_q == ST_RESP);
   assign rsp_rd_o      = rd_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_we_o      = rsp_we_q;
   assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl with a response scoreboard.
module tb_csr_access_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_funct3_i;
   logic [11:0] req_addr_i;
   logic [31:0] req_rs1_i;
   logic [4:0]  req_rs1_idx_i;
   logic [4:0]  req_rd_i;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_data_o;
   logic [1:0]  csr_op_o;
   logic        csr_we_o;
   logic [31:0] csr_data_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [4:0]  rsp_rd_o;
   logic [31:0] rsp_data_o;
   logic        rsp_we_o;
   logic        rsp_illegal_o;

   // Second instance with the address check disabled.
   logic        nc_req_ready;
   logic [11:0] nc_csr_addr;
   logic [31:0] nc_csr_data;
   logic [1:0]  nc_csr_op;
   logic        nc_csr_we;
   logic        nc_rsp_valid;
   logic [4:0]  nc_rsp_rd;
   logic [31:0] nc_rsp_data;
   logic        nc_rsp_we;
   logic        nc_rsp_illegal;

   logic [31:0] cyc;
   logic [31:0] csr_val;
   int          we_cnt;
   int          n_chk;
   int          n_pass;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        ill;
      logic        ill_nc;
   } exp_t;
   exp_t sb[$];

   csr_access_ctrl #(.CHECK_ADDR(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_rs1_i(req_rs1_i),
      .req_rs1_idx_i(req_rs1_idx_i), .req_rd_i(req_rd_i), .csr_addr_o(csr_addr_o),
      .csr_data_o(csr_data_o), .csr_op_o(csr_op_o), .csr_we_o(csr_we_o),
      .csr_data_i(csr_data_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rd_o(rsp_rd_o), .rsp_data_o(rsp_data_o), .rsp_we_o(rsp_we_o),
      .rsp_illegal_o(rsp_illegal_o)
   );

   csr_access_ctrl #(.CHECK_ADDR(1'b0)) dut_nc (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(nc_req_ready),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_rs1_i(req_rs1_i),
      .req_rs1_idx_i(req_rs1_idx_i), .req_rd_i(req_rd_i), .csr_addr_o(nc_csr_addr),
      .csr_data_o(nc_csr_data), .csr_op_o(nc_csr_op), .csr_we_o(nc_csr_we),
      .csr_data_i(csr_data_i), .rsp_valid_o(nc_rsp_valid), .rsp_ready_i(rsp_ready_i),
      .rsp_rd_o(nc_rsp_rd), .rsp_data_o(nc_rsp_data), .rsp_we_o(nc_rsp_we),
      .rsp_illegal_o(nc_rsp_illegal)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Simple CSR unit model: 0xC00 reads the free-running cycle count.
   assign csr_data_i = (csr_addr_o == 12'hC00) ? cyc : csr_val;

   always @(posedge clk_i) begin
      cyc <= cyc + 32'd1;
      if (csr_we_o) we_cnt <= we_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One full request; starts and ends at a falling edge.
   task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] idx, input logic [4:0] rd, input logic [31:0] cval,
                         input logic chk_csr, input logic [1:0] e_op, input logic [31:0] e_cdata,
                         input int e_pulses, input logic [31:0] e_data, input logic e_we,
                         input logic e_ill, input logic e_ill_nc, input int stall,
                         input logic hold_valid);
      exp_t e;
      int   n;
      int   we0;
      e.rd = rd; e.data = e_data; e.we = e_we; e.ill = e_ill; e.ill_nc = e_ill_nc;
      sb.push_back(e);
      req_valid_i   = 1'b1;
      req_funct3_i  = f3;
      req_addr_i    = addr;
      req_rs1_i     = rs1;
      req_rs1_idx_i = idx;
      req_rd_i      = rd;
      csr_val       = cval;
      we0           = we_cnt;
      n = 0;
      while (!req_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      n_chk++;
      if (!req_ready_o) $display("FAIL accept_timeout: req_ready_o=%b required 1", req_ready_o);
      else n_pass++;
      @(negedge clk_i);
      if (!hold_valid) req_valid_i = 1'b0;
      // ACCESS cycle
      n_chk++;
      if (req_ready_o !== 1'b0) $display("FAIL access_ready: got %b required 0", req_ready_o);
      else n_pass++;
      n_chk++;
      if (rsp_valid_o !== 1'b0) $display("FAIL access_rsp_valid: got %b required 0", rsp_valid_o);
      else n_pass++;
      n_chk++;
      if (csr_addr_o !== addr) $display("FAIL csr_addr: got %h required %h", csr_addr_o, addr);
      else n_pass++;
      if (chk_csr) begin
         n_chk++;
         if (csr_op_o !== e_op) $display("FAIL csr_op: got %b required %b", csr_op_o, e_op);
         else n_pass++;
         n_chk++;
         if (csr_data_o !== e_cdata) $display("FAIL csr_data: got %h required %h", csr_data_o, e_cdata);
         else n_pass++;
      end
      @(negedge clk_i);
      // RESP cycle
      n_chk++;
      if (we_cnt - we0 !== e_pulses) $display("FAIL csr_we_pulses: got %0d required %0d", we_cnt - we0, e_pulses);
      else n_pass++;
      n_chk++;
      if (rsp_valid_o !== 1'b1 || sb.size() == 0) begin
         $display("FAIL rsp_valid: got %b required 1", rsp_valid_o);
      end else begin
         n_pass++;
         e = sb.pop_front();
         n_chk++;
         if (rsp_rd_o !== e.rd) $display("FAIL rsp_rd: got %0d required %0d", rsp_rd_o, e.rd);
         else n_pass++;
         n_chk++;
         if (rsp_data_o !== e.data) $display("FAIL rsp_data: got %h required %h", rsp_data_o, e.data);
         else n_pass++;
         n_chk++;
         if (rsp_we_o !== e.we) $display("FAIL rsp_we: got %b required %b", rsp_we_o, e.we);
         else n_pass++;
         n_chk++;
         if (rsp_illegal_o !== e.ill) $display("FAIL rsp_illegal: got %b required %b", rsp_illegal_o, e.ill);
         else n_pass++;
         n_chk++;
         if (nc_rsp_illegal !== e.ill_nc) $display("FAIL nc_rsp_illegal: got %b required %b", nc_rsp_illegal, e.ill_nc);
         else n_pass++;
      end
      for (int s = 0; s < stall; s++) begin
         rsp_ready_i = 1'b0;
         @(negedge clk_i);
         n_chk++;
         if (rsp_valid_o !== 1'b1 || rsp_data_o !== e.data || rsp_rd_o !== e.rd || req_ready_o !== 1'b0)
            $display("FAIL stall_hold: valid=%b data=%h rd=%0d ready=%b required 1 %h %0d 0",
                     rsp_valid_o, rsp_data_o, rsp_rd_o, req_ready_o, e.data, e.rd);
         else n_pass++;
      end
      $display("txn f3=%b addr=%h rd=%0d rsp_data=%h rsp_we=%b illegal=%b", f3, addr, rsp_rd_o,
               rsp_data_o, rsp_we_o, rsp_illegal_o);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      n_chk++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
         $display("FAIL back_to_idle: rsp_valid=%b req_ready=%b required 0 1", rsp_valid_o, req_ready_o);
      else n_pass++;
      n_chk++;
      if (we_cnt - we0 !== e_pulses) $display("FAIL csr_we_total: got %0d required %0d", we_cnt - we0, e_pulses);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      n_chk++;
      if (req_ready_o !== 1'b0) $display("FAIL reset_ready: got %b required 0", req_ready_o);
      else n_pass++;
      n_chk++;
      if (rsp_valid_o !== 1'b0 || rsp_we_o !== 1'b0 || rsp_illegal_o !== 1'b0 ||
          rsp_data_o !== 32'h0 || rsp_rd_o !== 5'd0 || csr_we_o !== 1'b0)
         $display("FAIL reset_outputs: valid=%b we=%b ill=%b data=%h rd=%0d csr_we=%b required all 0",
                  rsp_valid_o, rsp_we_o, rsp_illegal_o, rsp_data_o, rsp_rd_o, csr_we_o);
      else n_pass++;
      rst_i = 1'b0;
      @(negedge clk_i);
      n_chk++;
      if (req_ready_o !== 1'b1) $display("FAIL idle_ready: got %b required 1", req_ready_o);
      else n_pass++;
   endtask

   task automatic test_csrrw();
      do_req(3'b001, 12'h301, 32'h1234, 5'd7, 5'd5, 32'h40001100,
             1'b1, 2'b00, 32'h1234, 1, 32'h40001100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_csrrs_read_cycle();
      logic [31:0] exp_cyc;
      exp_cyc = cyc + 32'd1;
      do_req(3'b010, 12'hC00, 32'hDEADBEEF, 5'd0, 5'd10, 32'h0,
             1'b1, 2'b01, 32'hDEADBEEF, 0, exp_cyc, 1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_ro_write();
      do_req(3'b011, 12'hF14, 32'h0000FFFF, 5'd3, 5'd4, 32'h0BADF00D,
             1'b1, 2'b10, 32'h0000FFFF, 0, 32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
   endtask

   task automatic test_illegal();
      do_req(3'b100, 12'h301, 32'h11, 5'd1, 5'd6, 32'h22,
             1'b0, 2'b00, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      do_req(3'b001, 12'h7C0, 32'h55, 5'd2, 5'd7, 32'h77,
             1'b1, 2'b00, 32'h55, 0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_immediates();
      // CSRRSI uses zimm as the operand
      do_req(3'b110, 12'h301, 32'hFFFFFFFF, 5'd5, 5'd8, 32'h8,
             1'b1, 2'b01, 32'h5, 1, 32'h8, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      // CSRRCI with zimm=0 and rd=0: no write, no register write
      do_req(3'b111, 12'h301, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h9,
             1'b1, 2'b10, 32'h0, 0, 32'h9, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_req(3'b001, 12'h301, 32'hA5A5, 5'd1, 5'd9, 32'h1357,
             1'b1, 2'b00, 32'hA5A5, 1, 32'h1357, 1'b1, 1'b0, 1'b0, 4, 1'b1);
      do_req(3'b010, 12'hC80, 32'h0, 5'd0, 5'd11, 32'h2468,
             1'b1, 2'b01, 32'h0, 0, 32'h2468, 1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int we0;
      we0           = we_cnt;
      req_valid_i   = 1'b1;
      req_funct3_i  = 3'b101;
      req_addr_i    = 12'h301;
      req_rs1_i     = 32'h0;
      req_rs1_idx_i = 5'd17;
      req_rd_i      = 5'd3;
      csr_val       = 32'h3;
      @(posedge clk_i);
      #1;
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      n_chk++;
      if (csr_we_o !== 1'b0) $display("FAIL reset_mid_we: got %b required 0", csr_we_o);
      else n_pass++;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      n_chk++;
      if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0)
         $display("FAIL reset_mid_idle: ready=%b rsp_valid=%b required 1 0", req_ready_o, rsp_valid_o);
      else n_pass++;
      repeat (2) @(negedge clk_i);
      n_chk++;
      if (rsp_valid_o !== 1'b0 || we_cnt != we0)
         $display("FAIL reset_mid_no_rsp: rsp_valid=%b we_pulses=%0d required 0 0", rsp_valid_o, we_cnt - we0);
      else n_pass++;
      $display("txn reset during ACCESS: request abandoned");
   endtask

   initial begin
      cyc           = 32'd0;
      we_cnt        = 0;
      n_chk         = 0;
      n_pass        = 0;
      csr_val       = 32'h0;
      rst_i         = 1'b1;
      req_valid_i   = 1'b0;
      req_funct3_i  = 3'd0;
      req_addr_i    = 12'd0;
      req_rs1_i     = 32'd0;
      req_rs1_idx_i = 5'd0;
      req_rd_i      = 5'd0;
      rsp_ready_i   = 1'b0;
      test_reset();
      test_csrrw();
      test_csrrs_read_cycle();
      test_ro_write();
      test_illegal();
      test_immediates();
      test_back_to_back();
      test_reset_mid();
      test_csrrw();
      n_chk++;
      if (sb.size() != 0) $display("FAIL scoreboard_left: %0d entries required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
